// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then presents the load data or store acknowledge until
// the requester takes it.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; req_ready high once out of reset
// S_WAIT | wait states counting down; request fields held in latches
// S_RESP | response presented; held stable until resp_ready
module data_memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    state_t                  state, state_nxt;
    logic                    live;
    logic [3:0]              cnt;
    logic                    accept, enter_resp;
    logic                    lat_write, lat_err;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    op_write, op_err;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_wdata;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    // With zero wait states the commit happens on the accept edge itself, so the
    // operation fields come straight from the request port while idle.
    always_comb begin
        op_write = lat_write;
        op_addr  = lat_addr;
        op_wdata = lat_wdata;
        op_err   = lat_err;
        if (state == S_IDLE) begin
            op_write = req_write;
            op_addr  = req_addr[ADDR_WIDTH-1:0];
            op_wdata = req_wdata;
            op_err   = (req_addr >> ADDR_WIDTH) != 32'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = live;
                if (req_valid && live) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latches, wait counter, response registers; live holds req_ready
    // low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live       <= 1'b0;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr[ADDR_WIDTH-1:0];
                lat_wdata <= req_wdata;
                lat_err   <= (req_addr >> ADDR_WIDTH) != 32'd0;
                cnt       <= WAIT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= op_err;
                resp_rdata <= (op_write || op_err) ? '0 : mem[op_addr];
            end
        end
    end

    // Storage is never cleared; a store commits only on entry to S_RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && op_write && !op_err) mem[op_addr] <= op_wdata;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder against a flat array model of
// the storage, plus a zero-wait-state instance for the fast path.
module tb_data_memory_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        fast_req_valid, fast_req_ready, fast_req_write;
    logic [31:0] fast_req_addr, fast_req_wdata;
    logic        fast_resp_valid, fast_resp_ready, fast_resp_err;
    logic [31:0] fast_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut_fast (
        .clk(clk), .reset(reset),
        .req_valid(fast_req_valid), .req_ready(fast_req_ready), .req_write(fast_req_write),
        .req_addr(fast_req_addr), .req_wdata(fast_req_wdata),
        .resp_valid(fast_resp_valid), .resp_ready(fast_resp_ready),
        .resp_rdata(fast_resp_rdata), .resp_err(fast_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // One transaction: expected response is derived from the address range
    // rule and the array model, latency counted in cycles from accept.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold);
        int          n;
        bit          err;
        logic [31:0] exp_rd, seen;
        err    = (addr >> 8) != 0;
        exp_rd = (wr || err) ? 32'd0 : ref_mem[addr[7:0]];
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        @(negedge clk);
        n = 1;
        while (n < 20) begin
            if (resp_valid) break;
            junk_req();
            resp_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(WS + 1));
        chk("rdata", resp_rdata, exp_rd);
        chk("err", 32'(resp_err), 32'(err));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        if (wr && !err) ref_mem[addr[7:0]] = wdata;
        seen = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            resp_ready = 1'b0;
            junk_req();
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, seen);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_valid", 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        fast_req_valid  = 1'b0;
        fast_req_write  = 1'b0;
        fast_req_addr   = '0;
        fast_req_wdata  = '0;
        fast_resp_ready = 1'b0;

        // Reset with junk inputs on the slow instance.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            junk_req();
            resp_ready = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        // Give every word a known value so loads are always predictable.
        for (int i = 0; i < 256; i++) txn(1'b1, 32'(i), $urandom, 0);

        txn(1'b1, 32'd5, 32'hDEADBEEF, 0);
        txn(1'b0, 32'd5, 32'd0, 0);
        txn(1'b0, 32'd5, 32'd0, 4);

        txn(1'b1, 32'h100, 32'h12345678, 0);
        txn(1'b0, 32'd0, 32'd0, 1);

        // Reset while a store sits in the wait states: it must not commit.
        txn(1'b1, 32'd7, 32'h1, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd7;
        req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("midwait_rst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midwait_no_resp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midwait_ready_back", 32'(req_ready), 32'd1);
        txn(1'b0, 32'd7, 32'd0, 0);

        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 5) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
            txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Zero-wait-state instance: store then load back to back.
        fast_resp_ready = 1'b1;
        fast_req_valid  = 1'b1;
        fast_req_write  = 1'b1;
        fast_req_addr   = 32'd3;
        fast_req_wdata  = 32'hCAFEF00D;
        chk("fast_ready", 32'(fast_req_ready), 32'd1);
        @(negedge clk);
        chk("fast_store_valid", 32'(fast_resp_valid), 32'd1);
        chk("fast_store_err", 32'(fast_resp_err), 32'd0);
        chk("fast_store_rdata", fast_resp_rdata, 32'd0);
        chk("fast_busy", 32'(fast_req_ready), 32'd0);
        fast_req_write = 1'b0;
        @(negedge clk);
        chk("fast_ready_again", 32'(fast_req_ready), 32'd1);
        chk("fast_idle_valid", 32'(fast_resp_valid), 32'd0);
        @(negedge clk);
        chk("fast_load_valid", 32'(fast_resp_valid), 32'd1);
        chk("fast_load_rdata", fast_resp_rdata, 32'hCAFEF00D);
        fast_req_valid = 1'b0;
        @(negedge clk);
        chk("fast_done_valid", 32'(fast_resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
